// File: rtl/vram_pkg.sv
// Shared types and default geometry for the VRAM burst scheduler.
package vram_pkg;

    localparam int unsigned DefAddrW = 14;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefLanes = 8;
    localparam int unsigned DefRdLat = 2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } sched_state_t;

    // Width of a lane index within one half of the burst, never below one bit.
    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        return (lanes / 2 > 1) ? $clog2(lanes / 2) : 1;
    endfunction

    localparam int unsigned DefIdxW = (DefLanes / 2 > 1) ? $clog2(DefLanes / 2) : 1;

    // Return-pipeline tag at the default geometry; the scheduler sizes its own copy.
    typedef struct packed {
        logic               valid;
        logic               is_io;
        logic [DefIdxW-1:0] idx;
    } vram_tag_t;

endpackage

// File: rtl/vram_dp_mem.sv
// True dual-port video RAM: port A read/write, port B read-only, RD_LAT-cycle reads.
module vram_dp_mem #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] a_pipe [RD_LAT];
    logic [DATA_W-1:0] b_pipe [RD_LAT];

    // Read-before-write on port A: a same-cycle read returns the old contents.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_pipe[0] <= mem[a_addr];
        b_pipe[0] <= mem[b_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end

    assign a_rdata = a_pipe[RD_LAT-1];
    assign b_rdata = b_pipe[RD_LAT-1];

endmodule

// File: rtl/vram_burst_sched.sv
// VRAM access scheduler: CPU I/O port plus a VGA burst port sharing a dual-port RAM.
module vram_burst_sched
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned LANES  = DefLanes,
    parameter int unsigned RD_LAT = DefRdLat
) (
    input  logic                    clk_100,
    input  logic                    rst,
    input  logic                    io_req,
    input  logic                    io_we,
    input  logic [ADDR_W-1:0]       io_addr,
    input  logic [DATA_W-1:0]       io_wdata,
    output logic                    io_ack,
    output logic                    io_rvalid,
    output logic [DATA_W-1:0]       io_rdata,
    input  logic                    vga_go,
    input  logic [LANES*ADDR_W-1:0] vga_addr,
    output logic [LANES*DATA_W-1:0] vga_data,
    output logic                    vga_valid,
    output logic                    busy,
    output logic                    go_overrun
);

    localparam int unsigned H     = LANES / 2;
    localparam int unsigned IDX_W = lane_idx_w(LANES);

    localparam logic [IDX_W-1:0] LastSlot = IDX_W'(H - 1);

    typedef struct packed {
        logic             valid;
        logic             is_io;
        logic [IDX_W-1:0] idx;
    } tag_t;

    sched_state_t            state_q, state_d;
    logic [IDX_W-1:0]        slot_q, slot_d;
    logic [LANES*ADDR_W-1:0] snap_q;
    tag_t                    tag_pipe_q [RD_LAT];
    tag_t                    tag_push;
    tag_t                    tag_out;
    logic [LANES*DATA_W-1:0] vga_data_q;
    logic [DATA_W-1:0]       io_rdata_q;
    logic                    overrun_q;

    logic [ADDR_W-1:0] a_addr, b_addr;
    logic              a_we;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              go_accept, io_accept, last_out;

    // Reset gates acceptance so nothing is written or started during a reset cycle.
    assign go_accept = !rst && (state_q == StIdle) && vga_go;
    assign io_accept = !rst && (state_q == StIdle) && !vga_go && io_req;
    assign tag_out   = tag_pipe_q[RD_LAT-1];
    assign last_out  = tag_out.valid && !tag_out.is_io && (tag_out.idx == LastSlot);

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        tag_push = '0;
        a_addr   = io_addr;
        a_we     = 1'b0;
        b_addr   = snap_q[(int'(slot_q) + H) * ADDR_W +: ADDR_W];

        case (state_q)
            StIdle: begin
                if (go_accept) begin
                    state_d = StIssue;
                    slot_d  = '0;
                end else if (io_accept) begin
                    a_we           = io_we;
                    tag_push.valid = !io_we;
                    tag_push.is_io = 1'b1;
                end
            end
            StIssue: begin
                a_addr         = snap_q[int'(slot_q) * ADDR_W +: ADDR_W];
                tag_push.valid = 1'b1;
                tag_push.idx   = slot_q;
                if (slot_q == LastSlot) begin
                    state_d = StDrain;
                    slot_d  = '0;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            StDrain: begin
                if (last_out) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state_q    <= StIdle;
            slot_q     <= '0;
            snap_q     <= '0;
            vga_data_q <= '0;
            io_rdata_q <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            tag_pipe_q[0] <= tag_push;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
            if (go_accept) begin
                snap_q <= vga_addr;
            end
            if (vga_go && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            if (tag_out.valid) begin
                if (tag_out.is_io) begin
                    io_rdata_q <= a_rdata;
                end else begin
                    vga_data_q[int'(tag_out.idx) * DATA_W +: DATA_W]       <= a_rdata;
                    vga_data_q[(int'(tag_out.idx) + H) * DATA_W +: DATA_W] <= b_rdata;
                end
            end
        end
    end

    vram_dp_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_mem (
        .clk     (clk_100),
        .a_addr  (a_addr),
        .a_we    (a_we),
        .a_wdata (io_wdata),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_rdata (b_rdata)
    );

    // Read data is forwarded in its return cycle and held in io_rdata_q afterwards.
    assign io_ack     = io_accept;
    assign io_rvalid  = tag_out.valid && tag_out.is_io;
    assign io_rdata   = io_rvalid ? a_rdata : io_rdata_q;
    assign vga_data   = vga_data_q;
    assign vga_valid  = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign go_overrun = overrun_q;

endmodule

// File: tb/tb_vram_burst_sched.sv
// Directed self-checking bench for vram_burst_sched at default parameters.
module tb_vram_burst_sched;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int L  = 8;

    logic            clk_100;
    logic            rst;
    logic            io_req;
    logic            io_we;
    logic [AW-1:0]   io_addr;
    logic [DW-1:0]   io_wdata;
    logic            io_ack;
    logic            io_rvalid;
    logic [DW-1:0]   io_rdata;
    logic            vga_go;
    logic [L*AW-1:0] vga_addr;
    logic [L*DW-1:0] vga_data;
    logic            vga_valid;
    logic            busy;
    logic            go_overrun;

    int n_vec = 0;
    int n_err = 0;

    vram_burst_sched #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LANES  (L),
        .RD_LAT (2)
    ) dut (
        .clk_100    (clk_100),
        .rst        (rst),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_ack     (io_ack),
        .io_rvalid  (io_rvalid),
        .io_rdata   (io_rdata),
        .vga_go     (vga_go),
        .vga_addr   (vga_addr),
        .vga_data   (vga_data),
        .vga_valid  (vga_valid),
        .busy       (busy),
        .go_overrun (go_overrun)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Address pattern per lane; RAM 0..7 is preloaded with 0x10 + address.
    function automatic int lane_addr(input int mode, input int i);
        case (mode)
            0:       return i;
            1:       return 7 - i;
            2:       return (i + 2) % 8;
            default: return (i + 5) % 8;
        endcase
    endfunction

    function automatic logic [L*DW-1:0] exp_data(input int mode);
        logic [L*DW-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++) begin
            r[i*DW +: DW] = 8'(8'h10 + lane_addr(mode, i));
        end
        return r;
    endfunction

    task automatic set_addrs(input int mode);
        for (int i = 0; i < L; i++) begin
            vga_addr[i*AW +: AW] = AW'(lane_addr(mode, i));
        end
    endtask

    task automatic io_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waited;
        waited   = 0;
        io_req   = 1'b1;
        io_we    = 1'b1;
        io_addr  = a;
        io_wdata = d;
        #1;
        while (io_ack !== 1'b1 && waited < 20) begin
            @(negedge clk_100);
            #1;
            waited++;
        end
        n_vec++;
        if (io_ack !== 1'b1) begin
            n_err++;
            $display("FAIL io_write_ack addr=%h got %b want 1", a, io_ack);
        end
        @(negedge clk_100);
        io_req = 1'b0;
        io_we  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; io_req = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
        vga_go = 1'b0; vga_addr = '0;
        repeat (2) @(negedge clk_100);
        #1;
        n_vec++;
        if ({io_ack, io_rvalid, vga_valid, busy, go_overrun} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 00000",
                     {io_ack, io_rvalid, vga_valid, busy, go_overrun});
        end
        n_vec++;
        if (io_rdata !== 8'h00) begin
            n_err++; $display("FAIL reset_io_rdata got %h want 00", io_rdata);
        end
        n_vec++;
        if (vga_data !== '0) begin
            n_err++; $display("FAIL reset_vga_data got %h want 0", vga_data);
        end
        @(negedge clk_100);
        rst = 1'b0;
    endtask

    task automatic test_io_rw;
        io_write(14'h0123, 8'hA5);
        io_req = 1'b1; io_we = 1'b0; io_addr = 14'h0123;
        #1;
        n_vec++;
        if (io_ack !== 1'b1) begin
            n_err++; $display("FAIL rd_ack got %b want 1", io_ack);
        end
        @(negedge clk_100);
        io_req = 1'b0;
        #1;
        n_vec++;
        if (io_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rd_rvalid_early got %b want 0", io_rvalid);
        end
        @(negedge clk_100);
        #1;
        n_vec++;
        if (io_rvalid !== 1'b1 || io_rdata !== 8'hA5) begin
            n_err++;
            $display("FAIL rd_return got v=%b d=%h want v=1 d=a5", io_rvalid, io_rdata);
        end
        @(negedge clk_100);
        #1;
        n_vec++;
        if (io_rvalid !== 1'b0 || io_rdata !== 8'hA5) begin
            n_err++;
            $display("FAIL rd_hold got v=%b d=%h want v=0 d=a5", io_rvalid, io_rdata);
        end
    endtask

    task automatic test_back_to_back;
        io_req = 1'b1; io_we = 1'b1; io_addr = 14'h0200; io_wdata = 8'h3C;
        #1;
        n_vec++;
        if (io_ack !== 1'b1) begin
            n_err++; $display("FAIL b2b_wr_ack got %b want 1", io_ack);
        end
        @(negedge clk_100);
        io_we = 1'b0;
        #1;
        n_vec++;
        if (io_ack !== 1'b1) begin
            n_err++; $display("FAIL b2b_rd_ack got %b want 1", io_ack);
        end
        @(negedge clk_100);
        io_req = 1'b0;
        #1;
        n_vec++;
        if (io_rvalid !== 1'b0) begin
            n_err++; $display("FAIL b2b_rvalid_early got %b want 0", io_rvalid);
        end
        @(negedge clk_100);
        #1;
        n_vec++;
        if (io_rvalid !== 1'b1 || io_rdata !== 8'h3C) begin
            n_err++;
            $display("FAIL b2b_return got v=%b d=%h want v=1 d=3c", io_rvalid, io_rdata);
        end
    endtask

    task automatic test_preload;
        for (int i = 0; i < 8; i++) begin
            io_write(AW'(i), 8'(8'h10 + i));
        end
    endtask

    task automatic test_burst;
        set_addrs(0);
        vga_go = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL burst_busy_c0 got %b want 0", busy);
        end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_100);
            if (c == 1) vga_go = 1'b0;
            #1;
            n_vec++;
            if (busy !== (c <= 7) || vga_valid !== (c == 7)) begin
                n_err++;
                $display("FAIL burst_timing c=%0d got busy=%b valid=%b want busy=%b valid=%b",
                         c, busy, vga_valid, (c <= 7), (c == 7));
            end
            if (c >= 7) begin
                n_vec++;
                if (vga_data !== exp_data(0)) begin
                    n_err++;
                    $display("FAIL burst_data c=%0d got %h want %h", c, vga_data, exp_data(0));
                end
            end
        end
    endtask

    task automatic test_go_priority;
        set_addrs(1);
        vga_go = 1'b1; io_req = 1'b1; io_we = 1'b0; io_addr = 14'h0005;
        #1;
        n_vec++;
        if (io_ack !== 1'b0) begin
            n_err++; $display("FAIL prio_ack_c0 got %b want 0", io_ack);
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_100);
            if (c == 1) vga_go = 1'b0;
            #1;
            n_vec++;
            if (io_ack !== (c == 8)) begin
                n_err++; $display("FAIL prio_ack c=%0d got %b want %b", c, io_ack, (c == 8));
            end
            if (c == 7) begin
                n_vec++;
                if (vga_valid !== 1'b1 || vga_data !== exp_data(1)) begin
                    n_err++;
                    $display("FAIL prio_burst got valid=%b data=%h want 1 %h",
                             vga_valid, vga_data, exp_data(1));
                end
            end
        end
        @(negedge clk_100);
        io_req = 1'b0;
        #1;
        n_vec++;
        if (io_rvalid !== 1'b0) begin
            n_err++; $display("FAIL prio_rvalid_early got %b want 0", io_rvalid);
        end
        @(negedge clk_100);
        #1;
        n_vec++;
        if (io_rvalid !== 1'b1 || io_rdata !== 8'h15) begin
            n_err++;
            $display("FAIL prio_io_return got v=%b d=%h want v=1 d=15", io_rvalid, io_rdata);
        end
    endtask

    task automatic test_overrun;
        set_addrs(2);
        n_vec++;
        if (go_overrun !== 1'b0) begin
            n_err++; $display("FAIL overrun_init got %b want 0", go_overrun);
        end
        vga_go = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_100);
            if (c == 1) vga_go = 1'b0;
            if (c == 3) vga_go = 1'b1;
            if (c == 4) vga_go = 1'b0;
            #1;
            n_vec++;
            if (busy !== (c <= 7) || vga_valid !== (c == 7) || go_overrun !== (c >= 4)) begin
                n_err++;
                $display("FAIL overrun_timing c=%0d got busy=%b valid=%b ovr=%b want %b %b %b",
                         c, busy, vga_valid, go_overrun, (c <= 7), (c == 7), (c >= 4));
            end
            if (c == 7) begin
                n_vec++;
                if (vga_data !== exp_data(2)) begin
                    n_err++;
                    $display("FAIL overrun_data got %h want %h", vga_data, exp_data(2));
                end
            end
        end
    endtask

    task automatic test_addr_change;
        set_addrs(0);
        vga_go = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_100);
            if (c == 1) begin
                vga_go = 1'b0;
                set_addrs(1);
            end
            #1;
            if (c == 7) begin
                n_vec++;
                if (vga_valid !== 1'b1 || vga_data !== exp_data(0)) begin
                    n_err++;
                    $display("FAIL addr_snapshot got valid=%b data=%h want 1 %h",
                             vga_valid, vga_data, exp_data(0));
                end
            end
        end
    endtask

    task automatic test_io_before_burst;
        io_req = 1'b1; io_we = 1'b0; io_addr = 14'h0123;
        #1;
        n_vec++;
        if (io_ack !== 1'b1) begin
            n_err++; $display("FAIL pre_ack got %b want 1", io_ack);
        end
        @(negedge clk_100);
        io_req = 1'b0;
        set_addrs(3);
        vga_go = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_100);
            if (c == 1) vga_go = 1'b0;
            #1;
            n_vec++;
            if (io_rvalid !== (c == 1) || vga_valid !== (c == 7)) begin
                n_err++;
                $display("FAIL pre_timing c=%0d got rv=%b valid=%b want %b %b",
                         c, io_rvalid, vga_valid, (c == 1), (c == 7));
            end
            if (c == 1) begin
                n_vec++;
                if (io_rdata !== 8'hA5) begin
                    n_err++; $display("FAIL pre_io_data got %h want a5", io_rdata);
                end
            end
            if (c == 7) begin
                n_vec++;
                if (vga_data !== exp_data(3) || io_rdata !== 8'hA5) begin
                    n_err++;
                    $display("FAIL pre_burst_data got %h io=%h want %h io=a5",
                             vga_data, io_rdata, exp_data(3));
                end
            end
        end
        n_vec++;
        if (go_overrun !== 1'b1) begin
            n_err++; $display("FAIL overrun_sticky got %b want 1", go_overrun);
        end
    endtask

    task automatic test_mid_reset;
        set_addrs(2);
        vga_go = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_100);
            if (c == 1) vga_go = 1'b0;
            if (c == 3) rst = 1'b1;
        end
        @(negedge clk_100);
        #1;
        n_vec++;
        if ({io_ack, io_rvalid, vga_valid, busy, go_overrun} !== 5'b0) begin
            n_err++;
            $display("FAIL midrst_flags got %b want 00000",
                     {io_ack, io_rvalid, vga_valid, busy, go_overrun});
        end
        n_vec++;
        if (vga_data !== '0 || io_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_data got vga=%h io=%h want 0 0", vga_data, io_rdata);
        end
        rst = 1'b0;
        for (int c = 5; c <= 10; c++) begin
            @(negedge clk_100);
            #1;
            n_vec++;
            if (vga_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_quiet c=%0d got valid=%b busy=%b want 0 0",
                         c, vga_valid, busy);
            end
        end
        set_addrs(1);
        vga_go = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_100);
            if (c == 1) vga_go = 1'b0;
            #1;
            n_vec++;
            if (busy !== (c <= 7) || vga_valid !== (c == 7)) begin
                n_err++;
                $display("FAIL fresh_timing c=%0d got busy=%b valid=%b want %b %b",
                         c, busy, vga_valid, (c <= 7), (c == 7));
            end
            if (c == 7) begin
                n_vec++;
                if (vga_data !== exp_data(1)) begin
                    n_err++;
                    $display("FAIL fresh_data got %h want %h", vga_data, exp_data(1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_io_rw();
        test_back_to_back();
        test_preload();
        test_burst();
        test_go_priority();
        test_overrun();
        test_addr_change();
        test_io_before_burst();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
